// File: rtl/pipe_fwd_unit_pkg.sv
// Shared types for the operand-forwarding unit: the forward-select encoding,
// the register-zero constant and the per-stage destination tag.
package pipe_fwd_unit_pkg;

    // Register-number width carried by every stage tag
    localparam int RN_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    localparam logic [RN_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic [RN_W-1:0] rn;
    } stage_tag_t;

    // A source hits a stage when it is read, is not r0, and the stage writes it
    function automatic logic tag_hit(input stage_tag_t tag, input logic use_src,
                                     input logic [RN_W-1:0] src);
        return use_src && (src != REG_ZERO) && tag.wreg && (tag.rn == src);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding selector: picks the youngest stage writing the source
// register (EXE > MEM > WB) and falls back to the register-file read.
module pipe_fwd_sel
    import pipe_fwd_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            use_src,
    input  logic [RN_W-1:0] src,
    input  logic            e_wreg,
    input  logic [RN_W-1:0] e_rn,
    input  logic            m_wreg,
    input  logic [RN_W-1:0] m_rn,
    input  logic            w_wreg,
    input  logic [RN_W-1:0] w_rn,
    input  logic [DW-1:0]   rf_val,
    input  logic [DW-1:0]   e_val,
    input  logic [DW-1:0]   m_val,
    input  logic [DW-1:0]   w_val,
    output logic [1:0]      sel,
    output logic [DW-1:0]   val
);

    stage_tag_t e_tag, m_tag, w_tag;
    fwd_sel_t   sel_q;

    assign e_tag = '{wreg: e_wreg, m2reg: 1'b0, rn: e_rn};
    assign m_tag = '{wreg: m_wreg, m2reg: 1'b0, rn: m_rn};
    assign w_tag = '{wreg: w_wreg, m2reg: 1'b0, rn: w_rn};

    // NOTE: both outputs get a default before the priority chain so no path
    // leaves them unassigned; otherwise synthesis would infer latches.
    always_comb begin
        sel_q = FWD_RF;
        val   = rf_val;
        if (tag_hit(e_tag, use_src, src)) begin
            sel_q = FWD_EXE;
            val   = e_val;
        end else if (tag_hit(m_tag, use_src, src)) begin
            sel_q = FWD_MEM;
            val   = m_val;
        end else if (tag_hit(w_tag, use_src, src)) begin
            sel_q = FWD_WB;
            val   = w_val;
        end
    end

    assign sel = sel_q;

endmodule

// File: rtl/pipe_fwd_unit.sv
// Operand-forwarding and load-use interlock unit. Tracks EXE/MEM/WB writers and
// bypasses their results to ID. Define FWD_STALL_CNT_EN to add stall/forward counters.
module pipe_fwd_unit
    import pipe_fwd_unit_pkg::*;
#(
    parameter int DW = 32,
    // Stage tags are RN_W wide, so RW must stay equal to RN_W
    parameter int RW = RN_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [RW-1:0] drs,
    input  logic [RW-1:0] drt,
    input  logic          duse_rs,
    input  logic          duse_rt,
    input  logic [DW-1:0] dqa,
    input  logic [DW-1:0] dqb,
    input  logic          dwreg,
    input  logic          dm2reg,
    input  logic          dflush,
    input  logic [RW-1:0] ern,
    input  logic [DW-1:0] ealu,
    input  logic [DW-1:0] mmo,
    output logic [DW-1:0] fa,
    output logic [DW-1:0] fb,
    output logic          stall,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   fwd_cnt
`endif
);

    logic          ewreg, em2reg;
    stage_tag_t    m_tag;
    logic [DW-1:0] malu;
    logic          wwreg;
    logic [RW-1:0] wrn;
    logic [DW-1:0] wdata;

    stage_tag_t    e_tag;
    logic [DW-1:0] m_val;
    logic          load_hit;

    assign e_tag = '{wreg: ewreg, m2reg: em2reg, rn: ern};

    // A load in MEM has its data on mmo now; anything else still holds its ALU result
    assign m_val = m_tag.m2reg ? mmo : malu;

    // Load still in EXE: its data does not exist yet, so ID must wait one cycle
    assign load_hit = e_tag.m2reg &&
                      (tag_hit(e_tag, duse_rs, drs) || tag_hit(e_tag, duse_rt, drt));
    assign stall    = load_hit;

    pipe_fwd_sel #(.DW(DW)) u_sel_a (
        .use_src (duse_rs),
        .src     (drs),
        .e_wreg  (ewreg),
        .e_rn    (ern),
        .m_wreg  (m_tag.wreg),
        .m_rn    (m_tag.rn),
        .w_wreg  (wwreg),
        .w_rn    (wrn),
        .rf_val  (dqa),
        .e_val   (ealu),
        .m_val   (m_val),
        .w_val   (wdata),
        .sel     (fwda),
        .val     (fa)
    );

    pipe_fwd_sel #(.DW(DW)) u_sel_b (
        .use_src (duse_rt),
        .src     (drt),
        .e_wreg  (ewreg),
        .e_rn    (ern),
        .m_wreg  (m_tag.wreg),
        .m_rn    (m_tag.rn),
        .w_wreg  (wwreg),
        .w_rn    (wrn),
        .rf_val  (dqb),
        .e_val   (ealu),
        .m_val   (m_val),
        .w_val   (wdata),
        .sel     (fwdb),
        .val     (fb)
    );

    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge value of the stage before it, like a real pipeline register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            m_tag  <= '0;
            malu   <= '0;
            wwreg  <= 1'b0;
            wrn    <= '0;
            wdata  <= '0;
        end else begin
            // A stalled or flushed ID instruction enters EXE as a bubble
            ewreg      <= dwreg  & ~stall & ~dflush;
            em2reg     <= dm2reg & ~stall & ~dflush;
            m_tag.wreg  <= ewreg;
            m_tag.m2reg <= em2reg;
            m_tag.rn    <= ern;
            malu       <= ealu;
            wwreg      <= m_tag.wreg;
            wrn        <= m_tag.rn;
            wdata      <= m_val;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic fwd_event;

    assign fwd_event = ((fwda != FWD_RF) || (fwdb != FWD_RF)) && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (fwd_event && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_fwd_unit.sv
// Directed self-checking bench for pipe_fwd_unit; define FWD_STALL_CNT_EN to
// also check the stall counter.
module tb_pipe_fwd_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  drs, drt, ern;
    logic        duse_rs, duse_rt, dwreg, dm2reg, dflush;
    logic [31:0] dqa, dqb, ealu, mmo;
    logic [31:0] fa, fb;
    logic        stall;
    logic [1:0]  fwda, fwdb;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] QA = 32'h1111_1111;
    localparam logic [31:0] QB = 32'h2222_2222;

    pipe_fwd_unit #(.DW(32), .RW(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .drs     (drs),
        .drt     (drt),
        .duse_rs (duse_rs),
        .duse_rt (duse_rt),
        .dqa     (dqa),
        .dqb     (dqb),
        .dwreg   (dwreg),
        .dm2reg  (dm2reg),
        .dflush  (dflush),
        .ern     (ern),
        .ealu    (ealu),
        .mmo     (mmo),
        .fa      (fa),
        .fb      (fb),
        .stall   (stall),
        .fwda    (fwda),
        .fwdb    (fwdb)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns after it, checks 1 ns later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic id_idle();
        drs = '0; drt = '0; duse_rs = 1'b0; duse_rt = 1'b0;
        dwreg = 1'b0; dm2reg = 1'b0; dflush = 1'b0;
    endtask

    task automatic drain();
        id_idle();
        ern = '0; ealu = '0; mmo = '0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        id_idle();
        dqa = QA; dqb = QB; ern = '0; ealu = '0; mmo = '0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwda", 32'(fwda), 32'd0);
        chk("rst_fwdb", 32'(fwdb), 32'd0);
        chk("rst_fa", fa, QA);
        chk("rst_fb", fb, QB);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rel_stall", 32'(stall), 32'd0);
        chk("rel_fa", fa, QA);
        chk("rel_fb", fb, QB);
`ifdef FWD_STALL_CNT_EN
        chk("rel_stall_cnt", stall_cnt, 32'd0);
`endif

        // add r3 travels EXE -> MEM -> WB while ID keeps reading r3
        dwreg = 1'b1;
        tick();
        dwreg = 1'b0; ern = 5'd3; ealu = 32'h5; drs = 5'd3; duse_rs = 1'b1;
        #1;
        chk("alu_exe_sel", 32'(fwda), 32'd1);
        chk("alu_exe_val", fa, 32'h5);
        chk("alu_exe_stall", 32'(stall), 32'd0);
        tick();
        ern = '0; ealu = '0;
        #1;
        chk("alu_mem_sel", 32'(fwda), 32'd2);
        chk("alu_mem_val", fa, 32'h5);
        tick();
        #1;
        chk("alu_wb_sel", 32'(fwda), 32'd3);
        chk("alu_wb_val", fa, 32'h5);
        tick();
        #1;
        chk("alu_rf_sel", 32'(fwda), 32'd0);
        chk("alu_rf_val", fa, QA);
        drain();

        // lw r4 in EXE, dependent add r5 reading rt=r4 stalls once
        dwreg = 1'b1; dm2reg = 1'b1;
        tick();
        dm2reg = 1'b0; ern = 5'd4; ealu = 32'h100; drt = 5'd4; duse_rt = 1'b1;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_stall_sel", 32'(fwdb), 32'd1);
        tick();
        ern = '0; ealu = '0; mmo = 32'hDEAD_BEEF;
        #1;
        chk("lu_after_stall", 32'(stall), 32'd0);
        chk("lu_mem_sel", 32'(fwdb), 32'd2);
        chk("lu_mem_val", fb, 32'hDEAD_BEEF);
        chk("lu_rs_sel", 32'(fwda), 32'd0);
        tick();
        // add r5 now in EXE, load result in WB
        dwreg = 1'b0; ern = 5'd5; ealu = 32'h55; mmo = '0;
        drs = 5'd5; duse_rs = 1'b1;
        #1;
        chk("lu_add_sel", 32'(fwda), 32'd1);
        chk("lu_add_val", fa, 32'h55);
        chk("lu_wb_sel", 32'(fwdb), 32'd3);
        chk("lu_wb_val", fb, 32'hDEAD_BEEF);
        drain();

        // writer to r0 is never forwarded
        dwreg = 1'b1;
        tick();
        dwreg = 1'b0; ern = 5'd0; ealu = 32'hFFFF_FFFF; drs = 5'd0; duse_rs = 1'b1;
        #1;
        chk("r0_sel", 32'(fwda), 32'd0);
        chk("r0_val", fa, QA);
        drain();

        // three writers to r7 in a row: EXE beats MEM beats WB
        dwreg = 1'b1;
        tick();
        ern = 5'd7; ealu = 32'h1;
        tick();
        ealu = 32'h2;
        tick();
        dwreg = 1'b0; ealu = 32'h3; drs = 5'd7; duse_rs = 1'b1; drt = 5'd7; duse_rt = 1'b1;
        #1;
        chk("pri_exe_sel", 32'(fwda), 32'd1);
        chk("pri_exe_a", fa, 32'h3);
        chk("pri_exe_b", fb, 32'h3);
        tick();
        ern = '0; ealu = '0;
        #1;
        chk("pri_mem_sel", 32'(fwdb), 32'd2);
        chk("pri_mem_val", fb, 32'h3);
        drain();

        // jal: EXE destination already forced to r31
        dwreg = 1'b1;
        tick();
        dwreg = 1'b0; ern = 5'd31; ealu = 32'h0040_0008; drs = 5'd31; duse_rs = 1'b1;
        #1;
        chk("jal_sel", 32'(fwda), 32'd1);
        chk("jal_val", fa, 32'h0040_0008);
        drain();

        // flushed writer to r9 never becomes a forwarding source
        dwreg = 1'b1; dflush = 1'b1;
        tick();
        dwreg = 1'b0; dflush = 1'b0; ern = 5'd9; ealu = 32'h99; drs = 5'd9; duse_rs = 1'b1;
        #1;
        chk("flush_sel", 32'(fwda), 32'd0);
        chk("flush_val", fa, QA);
        drain();

        // stall and flush together: EXE receives a bubble
        dwreg = 1'b1; dm2reg = 1'b1;
        tick();
        dm2reg = 1'b0; dflush = 1'b1; ern = 5'd4; ealu = 32'h200; drs = 5'd4; duse_rs = 1'b1;
        #1;
        chk("sf_stall", 32'(stall), 32'd1);
        tick();
        dwreg = 1'b0; dflush = 1'b0; ern = 5'd6; ealu = 32'h66; drs = 5'd6;
        #1;
        chk("sf_bubble_sel", 32'(fwda), 32'd0);
        chk("sf_bubble_stall", 32'(stall), 32'd0);
        drain();

        // back-to-back loads to r4, each consumer stalls exactly once
        dwreg = 1'b1; dm2reg = 1'b1;
        tick();
        ern = 5'd4; ealu = 32'h300; drs = 5'd4; duse_rs = 1'b1;
        #1;
        chk("b2b_stall1", 32'(stall), 32'd1);
        tick();
        ern = '0; ealu = '0; mmo = 32'hA0A0_A0A0;
        #1;
        chk("b2b_go1", 32'(stall), 32'd0);
        chk("b2b_val1", fa, 32'hA0A0_A0A0);
        tick();
        dwreg = 1'b0; dm2reg = 1'b0; ern = 5'd4; ealu = 32'h304; mmo = '0;
        duse_rs = 1'b0; drs = '0; drt = 5'd4; duse_rt = 1'b1;
        #1;
        chk("b2b_stall2", 32'(stall), 32'd1);
        chk("b2b_stall2_sel", 32'(fwdb), 32'd1);
        tick();
        ern = '0; ealu = '0; mmo = 32'hB0B0_B0B0;
        #1;
        chk("b2b_go2", 32'(stall), 32'd0);
        chk("b2b_sel2", 32'(fwdb), 32'd2);
        chk("b2b_val2", fb, 32'hB0B0_B0B0);
`ifdef FWD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd4);
`endif
        drain();

        // reset mid-interlock drops stall without waiting for an edge
        dwreg = 1'b1; dm2reg = 1'b1;
        tick();
        dwreg = 1'b0; dm2reg = 1'b0; ern = 5'd4; drt = 5'd4; duse_rt = 1'b1;
        #1;
        chk("mid_pre_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_fwdb", 32'(fwdb), 32'd0);
        chk("mid_rst_fb", fb, QB);
`ifdef FWD_STALL_CNT_EN
        chk("mid_rst_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_fwd_unit.md
Name: pipe_fwd_unit

Overview:
- Operand-forwarding and interlock unit; consumer of the execute-stage results (ealu, ern).
- Tracks the destination register and write flags of the instructions in EXE, MEM and WB.
- Supplies the ID stage with forwarded operands, and a stall when a load result is not yet available.
- Sits between the ID/EXE register and the EXE/MEM register. Owns the MEM/WB shadow copies of the result data used for bypass.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-number width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- drs  input  RW  ID source register rs.
- drt  input  RW  ID source register rt.
- duse_rs  input  1  ID instruction reads rs.
- duse_rt  input  1  ID instruction reads rt.
- dqa  input  DW  register-file read of rs.
- dqb  input  DW  register-file read of rt.
- dwreg  input  1  ID instruction writes a register.
- dm2reg  input  1  ID instruction is a load.
- dflush  input  1  squash the ID instruction (taken branch/jump).
- ern  input  RW  EXE destination register (already forced to 31 for jal).
- ealu  input  DW  EXE result.
- mmo  input  DW  memory read data of the MEM-stage instruction.
- fa  output  DW  forwarded operand A.
- fb  output  DW  forwarded operand B.
- stall  output  1  hold PC and IF/ID, insert bubble into EXE.
- fwda  output  2  source select for A: 0 RF, 1 EXE, 2 MEM, 3 WB.
- fwdb  output  2  source select for B, same encoding.

Behaviour:
- State registers:
  - ewreg, em2reg.
  - mwreg, mm2reg, mrn, malu.
  - wwreg, wrn, wdata.
- Reset (asynchronous, active-high): all write/load flags 0; mrn, wrn, malu, wdata 0. Consequently stall=0, fwda=fwdb=0, fa=dqa, fb=dqb.
- Each rising edge, when not in reset:
  - EXE slot: ewreg <= dwreg & ~stall & ~dflush; em2reg <= dm2reg & ~stall & ~dflush.
  - MEM slot: mwreg <= ewreg; mm2reg <= em2reg; mrn <= ern; malu <= ealu.
  - WB slot: wwreg <= mwreg; wrn <= mrn; wdata <= (mm2reg ? mmo : malu).
- Match rule: a source matches a stage when:
  - its use bit is 1;
  - the source register is nonzero (register 0 is never forwarded);
  - the stage's write flag is 1;
  - the stage's destination equals the source register.
- Forward priority, evaluated per operand: EXE (value ealu) > MEM (value mmo if mm2reg, else malu) > WB (value wdata) > register file.
- Load-use interlock: stall = 1 when the EXE slot has em2reg=1 and matches either used source. All of this is combinational.
  - While stall=1, fa/fb still reflect the priority mux; the ID stage discards them.
  - The interlock lasts exactly one cycle. After the bubble, the load is in MEM and is forwarded from mmo.
- Simultaneous stall and dflush: the bubble wins; the EXE slot receives no write.
- Back-to-back loads to the same register: each follows the same single-cycle interlock rule; no extra cycles.
- Latency: forwarding is zero-cycle combinational; state advances one stage per clock, no enable.
- Reset asserted mid-operation: all in-flight write flags clear immediately and stall drops in the same cycle.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits, reset 0). It increments on every rising edge where stall=1 and saturates at all-ones.
  - Adds output fwd_cnt (32 bits, reset 0). It increments on every edge where fwda≠0 or fwdb≠0 and stall=0, saturating.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - Forward-select encodings FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_WB=3.
  - Register-zero constant.
  - Stage-tag record (wreg, m2reg, rn).
- One natural sub-module: pipe_fwd_sel.
  - Purely combinational per-operand priority matcher and 4:1 mux.
  - Instantiated twice, for A and B.
- Stage registers and interlock logic live in the top.

Test Plan:
- Reset held, then released: stall=0, fwda=fwdb=0, fa=dqa=0x11111111, fb=dqb=0x22222222.
- Dependent ALU ops: add r3 into EXE with ealu=0x00000005, ID reads rs=r3 → fwda=1, fa=0x00000005. Next cycle (no new writer) → fwda=2, fa=0x00000005. Next → fwda=3, then fwda=0.
- Load-use: lw r4 in EXE (em2reg=1), ID reads rt=r4 → stall=1 for exactly one cycle. Next cycle mmo=0xDEADBEEF → fwdb=2, fb=0xDEADBEEF, stall=0.
- r0 destination: ern=0 with ewreg=1, ealu=0xFFFFFFFF, ID reads r0 → fwda=0, fa=dqa.
- Priority: r7 written in WB (wdata=1), MEM (malu=2) and EXE (ealu=3) → fa=3. jal in EXE (ern=31) with ID reading r31 → fa=ealu.
- dflush=1 on a writer to r9 → following cycle ID reading r9 sees fwda=0. With FWD_STALL_CNT_EN, three load-use stalls → stall_cnt=3.
